// File: rtl/nrisc_prog_loader_if.sv
// nrisc_prog_loader_if
//   Bundles the load-stream handshake, the instruction-memory program port and
//   the loader status flags of nrisc_prog_loader.
//   Parameter AW : program-address width (must match the loader's AW).
//   modport master : host / system side (drives LOAD_start, LOAD_byte, LOAD_valid)
//   modport slave  : the loader itself (drives ready, program port and status)
interface nrisc_prog_loader_if #(
  parameter int AW = 10
);
  logic          LOAD_start;
  logic [7:0]    LOAD_byte;
  logic          LOAD_valid;
  logic          LOAD_ready;
  logic          IDATA_PROG_write;
  logic [AW-1:0] IDATA_PROG_addr;
  logic [15:0]   IDATA_PROG_data;
  logic          CORE_hold;
  logic          LOAD_busy;
  logic          LOAD_done;
  logic          LOAD_error;

  modport master (
    output LOAD_start, LOAD_byte, LOAD_valid,
    input  LOAD_ready, IDATA_PROG_write, IDATA_PROG_addr, IDATA_PROG_data,
    input  CORE_hold, LOAD_busy, LOAD_done, LOAD_error
  );

  modport slave (
    input  LOAD_start, LOAD_byte, LOAD_valid,
    output LOAD_ready, IDATA_PROG_write, IDATA_PROG_addr, IDATA_PROG_data,
    output CORE_hold, LOAD_busy, LOAD_done, LOAD_error
  );
endinterface

// File: rtl/nrisc_prog_loader.sv
// nrisc_prog_loader
//   Receives a byte stream (count high, count low, N words high byte first,
//   optional checksum byte) and writes the words into the instruction memory
//   program port at addresses 0..N-1, holding the core in reset until a load
//   completes successfully.
//
//   Ports:
//     clk  : single clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : nrisc_prog_loader_if.slave (load handshake, program port, status)
//
//   Parameters:
//     LENGTH : instruction-memory depth in words, maximum accepted count
//     AW     : program-address width, 2**AW >= LENGTH
//
//   Build option:
//     NRISC_LOADER_CHECKSUM_EN : when defined, a trailing byte must equal the
//       mod-256 sum of all data bytes; otherwise the last write ends the load.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | after reset, waiting for LOAD_start
//   LEN_H | expecting count high byte
//   LEN_L | expecting count low byte, range-checked on acceptance
//   DAT_H | expecting high byte of the current word
//   DAT_L | expecting low byte of the current word
//   WR    | one-cycle write strobe to the program port
//   CHK   | expecting checksum byte (checksum build only)
//   DONE  | load succeeded, core released
//   ERR   | bad count or checksum, core held
module nrisc_prog_loader #(
  parameter int LENGTH = 1024,
  parameter int AW     = 10
) (
  input logic             clk,
  input logic             rst,
  nrisc_prog_loader_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_DAT_H,
    S_DAT_L,
    S_WR,
`ifdef NRISC_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] LEN_MAX = 17'(LENGTH);

  state_t        state_q, state_d;
  logic [15:0]   len_q;
  logic [7:0]    hi_q;
  logic [AW-1:0] widx_q;
`ifdef NRISC_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q;
`endif

  logic          ready_q;
  logic          write_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   data_q;
  logic          hold_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic          accept;
  logic [15:0]   n_w;
  logic          len_ok;
  logic          last_word;

  // ready_q is a registered function of the current state, so it can gate
  // acceptance directly.
  assign accept    = bus.LOAD_valid & ready_q;
  assign n_w       = {len_q[15:8], bus.LOAD_byte};
  assign len_ok    = (n_w != 16'd0) && ({1'b0, n_w} <= LEN_MAX);
  assign last_word = ((17'(widx_q) + 17'd1) == {1'b0, len_q});

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (bus.LOAD_start) state_d = S_LEN_H;
      S_LEN_H:               if (accept) state_d = S_LEN_L;
      S_LEN_L:               if (accept) state_d = len_ok ? S_DAT_H : S_ERR;
      S_DAT_H:               if (accept) state_d = S_DAT_L;
      S_DAT_L:               if (accept) state_d = S_WR;
      S_WR: begin
        if (!last_word) begin
          state_d = S_DAT_H;
        end else begin
`ifdef NRISC_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef NRISC_LOADER_CHECKSUM_EN
      S_CHK: if (accept) state_d = (bus.LOAD_byte == sum_q) ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      hi_q    <= '0;
      widx_q  <= '0;
`ifdef NRISC_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
      ready_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.LOAD_start) begin
            widx_q <= '0;
`ifdef NRISC_LOADER_CHECKSUM_EN
            sum_q  <= '0;
`endif
          end
        end
        S_LEN_H: if (accept) len_q[15:8] <= bus.LOAD_byte;
        S_LEN_L: if (accept) len_q[7:0]  <= bus.LOAD_byte;
        S_DAT_H: begin
          if (accept) begin
            hi_q  <= bus.LOAD_byte;
`ifdef NRISC_LOADER_CHECKSUM_EN
            sum_q <= sum_q + bus.LOAD_byte;
`endif
          end
        end
        S_DAT_L: begin
          // Address/data are only loaded on the way into WR, so they hold
          // their last values everywhere else.
          if (accept) begin
            addr_q <= widx_q;
            data_q <= {hi_q, bus.LOAD_byte};
`ifdef NRISC_LOADER_CHECKSUM_EN
            sum_q  <= sum_q + bus.LOAD_byte;
`endif
          end
        end
        S_WR:    widx_q <= widx_q + 1'b1;
        default: ;
      endcase

      // Outputs are registered from the next state so they line up with it.
      ready_q <= state_d inside {S_LEN_H, S_LEN_L, S_DAT_H, S_DAT_L
`ifdef NRISC_LOADER_CHECKSUM_EN
                                 , S_CHK
`endif
                                };
      write_q <= (state_d == S_WR);
      busy_q  <= !(state_d inside {S_IDLE, S_DONE, S_ERR});
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
      hold_q  <= (state_d != S_DONE);
    end
  end

  assign bus.LOAD_ready       = ready_q;
  assign bus.IDATA_PROG_write = write_q;
  assign bus.IDATA_PROG_addr  = addr_q;
  assign bus.IDATA_PROG_data  = data_q;
  assign bus.CORE_hold        = hold_q;
  assign bus.LOAD_busy        = busy_q;
  assign bus.LOAD_done        = done_q;
  assign bus.LOAD_error       = err_q;

endmodule

// File: tb/tb_nrisc_prog_loader.sv
module tb_nrisc_prog_loader;
  localparam int LENGTH = 1024;
  localparam int AW     = 10;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nrisc_prog_loader_if #(.AW(AW)) bus ();
  nrisc_prog_loader #(.LENGTH(LENGTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   passes = 0;
  int   total  = 0;
  wr_t  wq[$];
  int   viol = 0;
  logic prev_wr = 1'b0;

  // Write monitor: logs every strobe; a strobe while ready is high or a
  // strobe lasting two cycles is a protocol violation.
  always @(negedge clk) begin
    if (bus.IDATA_PROG_write === 1'b1) begin
      wq.push_back('{int'(bus.IDATA_PROG_addr), bus.IDATA_PROG_data});
      if (bus.LOAD_ready !== 1'b0) viol++;
      if (prev_wr) viol++;
    end
    prev_wr = (bus.IDATA_PROG_write === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.LOAD_start = 1'b1;
    tick();
    bus.LOAD_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int mode);
    int gap;
    int n;
    gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
    repeat (gap) tick();
    bus.LOAD_valid = 1'b1;
    bus.LOAD_byte  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.LOAD_ready === 1'b1) break;
      n++;
      if (n > 20) begin
        chk("send_timeout_ready", 32'(bus.LOAD_ready), 32'd1);
        tick();
        bus.LOAD_valid = 1'b0;
        return;
      end
    end
    tick();
    bus.LOAD_valid = 1'b0;
    bus.LOAD_byte  = 8'($urandom);
  endtask

  // Stream builder: count, words high byte first, optional checksum byte.
  // csum_mode 0 = correct sum, 1 = sum+1, 2 = literal 00h.
  function automatic bq_t build(input logic [15:0] n, input logic [15:0] w[$], input int csum_mode);
    bq_t q;
    logic [7:0] s;
    q = {};
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
    s = 8'd0;
    foreach (w[i]) begin
      q.push_back(w[i][15:8]);
      q.push_back(w[i][7:0]);
      s = s + w[i][15:8] + w[i][7:0];
    end
`ifdef NRISC_LOADER_CHECKSUM_EN
    if (csum_mode == 0) q.push_back(s);
    else if (csum_mode == 1) q.push_back(s + 8'd1);
    else q.push_back(8'h00);
`else
    if (csum_mode < 0) q.push_back(s);
`endif
    return q;
  endfunction

  // Full load with reference-model checking. start_at >= 0 pulses LOAD_start
  // after that byte index has been sent (must be ignored mid-load).
  task automatic run_load(input bq_t s, input int mode, input string tag, input int start_at);
    int          n;
    bit          ok;
    bit          exp_ok;
    int          nsend;
    int          nexp;
    int          k;
    logic [7:0]  sum;
    logic [15:0] d;
    wq.delete();
    viol = 0;
    pulse_start();
    chk({tag, "_busy_after_start"}, 32'(bus.LOAD_busy), 32'd1);
    chk({tag, "_hold_after_start"}, 32'(bus.CORE_hold), 32'd1);

    n      = int'({s[0], s[1]});
    ok     = (n >= 1) && (n <= LENGTH);
    exp_ok = ok;
    nsend  = ok ? s.size() : 2;
`ifdef NRISC_LOADER_CHECKSUM_EN
    if (ok) begin
      sum = 8'd0;
      for (int i = 2; i < 2 + 2 * n; i++) sum = sum + s[i];
      exp_ok = (s[2 + 2 * n] == sum);
    end
`else
    sum = 8'd0;
`endif

    for (int i = 0; i < nsend; i++) begin
      send_byte(s[i], mode);
      if (i == start_at) pulse_start();
    end

    k = 0;
    while (bus.LOAD_busy === 1'b1 && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_settle_busy"}, 32'(bus.LOAD_busy), 32'd0);
    chk({tag, "_done"},  32'(bus.LOAD_done),  32'(exp_ok));
    chk({tag, "_error"}, 32'(bus.LOAD_error), 32'(!exp_ok));
    chk({tag, "_hold"},  32'(bus.CORE_hold),  32'(!exp_ok));
    chk({tag, "_ready"}, 32'(bus.LOAD_ready), 32'd0);
    chk({tag, "_write"}, 32'(bus.IDATA_PROG_write), 32'd0);

    nexp = ok ? n : 0;
    chk({tag, "_nwrites"}, 32'(wq.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < wq.size(); i++) begin
      d = {s[2 + 2 * i], s[3 + 2 * i]};
      chk($sformatf("%s_addr%0d", tag, i), 32'(wq[i].addr), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(wq[i].data), 32'(d));
    end
    if (ok) begin
      chk({tag, "_addr_hold"}, 32'(bus.IDATA_PROG_addr), 32'(n - 1));
      chk({tag, "_data_hold"}, 32'(bus.IDATA_PROG_data), 32'({s[2 * n], s[2 * n + 1]}));
    end
    chk({tag, "_protocol"}, 32'(viol), 32'd0);
  endtask

  initial begin
    logic [15:0] w[$];
    bq_t         s;
    int          n;

    bus.LOAD_start = 1'b0;
    bus.LOAD_valid = 1'b0;
    bus.LOAD_byte  = 8'h00;

    // Reset values
    repeat (3) tick();
    chk("rst_ready", 32'(bus.LOAD_ready), 32'd0);
    chk("rst_busy",  32'(bus.LOAD_busy),  32'd0);
    chk("rst_done",  32'(bus.LOAD_done),  32'd0);
    chk("rst_error", 32'(bus.LOAD_error), 32'd0);
    chk("rst_hold",  32'(bus.CORE_hold),  32'd1);
    chk("rst_write", 32'(bus.IDATA_PROG_write), 32'd0);
    chk("rst_addr",  32'(bus.IDATA_PROG_addr),  32'd0);
    chk("rst_data",  32'(bus.IDATA_PROG_data),  32'd0);
    rst = 1'b1;
    tick();

    // Bytes while idle must be ignored
    bus.LOAD_valid = 1'b1;
    bus.LOAD_byte  = 8'h55;
    tick();
    chk("idle_ready", 32'(bus.LOAD_ready), 32'd0);
    chk("idle_busy",  32'(bus.LOAD_busy),  32'd0);
    bus.LOAD_valid = 1'b0;

    // Basic two-word load
    w = '{16'h1234, 16'hABCD};
    s = build(16'd2, w, 0);
    run_load(s, 0, "basic", -1);
    if (wq.size() == 2) begin
      chk("basic_w0_const", 32'(wq[0].data), 32'h1234);
      chk("basic_w1_const", 32'(wq[1].data), 32'hABCD);
    end

    // Count out of range
    w = {};
    run_load(build(16'd0, w, 0), 0, "len_zero", -1);
    run_load(build(16'h0401, w, 0), 0, "len_1025", -1);

    // Valid toggling every other cycle
    w = '{16'h1234, 16'hABCD};
    run_load(build(16'd2, w, 0), 1, "toggle", -1);

    // Reset mid-load after data byte 12h
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.LOAD_ready), 32'd0);
    chk("mid_rst_busy",  32'(bus.LOAD_busy),  32'd0);
    chk("mid_rst_done",  32'(bus.LOAD_done),  32'd0);
    chk("mid_rst_error", 32'(bus.LOAD_error), 32'd0);
    chk("mid_rst_hold",  32'(bus.CORE_hold),  32'd1);
    chk("mid_rst_write", 32'(bus.IDATA_PROG_write), 32'd0);
    chk("mid_rst_addr",  32'(bus.IDATA_PROG_addr),  32'd0);
    chk("mid_rst_data",  32'(bus.IDATA_PROG_data),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.LOAD_valid = 1'b1;
    bus.LOAD_byte  = 8'h34;
    repeat (4) tick();
    bus.LOAD_valid = 1'b0;
    chk("mid_rst_no_write", 32'(wq.size()), 32'd0);
    chk("mid_rst_idle_busy", 32'(bus.LOAD_busy), 32'd0);
    w = '{16'h1234, 16'hABCD};
    run_load(build(16'd2, w, 0), 0, "after_rst", -1);

    // LOAD_start pulsed while in DAT_L (after byte 12h)
    run_load(build(16'd2, w, 0), 0, "start_in_datl", 2);

`ifdef NRISC_LOADER_CHECKSUM_EN
    // Correct data with checksum 00h, and with an off-by-one checksum
    run_load(build(16'd2, w, 2), 0, "csum_zero", -1);
    w = '{16'h0001, 16'h0203, 16'hFFFF};
    run_load(build(16'd3, w, 1), 2, "csum_bad", -1);
`endif

    // Randomised loads
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 12));
      w = {};
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      run_load(build(16'(n), w, 0), 2, $sformatf("rand%0d", r), -1);
    end
    for (int r = 0; r < 3; r++) begin
      w = {};
      run_load(build(16'($urandom_range(LENGTH + 1, 65535)), w, 0), 2,
               $sformatf("rand_badlen%0d", r), -1);
    end

    // Maximum-size load, last address LENGTH-1
    w = {};
    for (int i = 0; i < LENGTH; i++) w.push_back(16'($urandom));
    run_load(build(16'(LENGTH), w, 0), 0, "max_len", -1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
